// File: rtl/vignette_update_ctrl_pkg.sv
// Shared definitions for the vignette coefficient loader: stream data-type
// codes, coefficient table selects, FSM state encodings and sizing helpers.
package vignette_update_ctrl_pkg;

  localparam int DTYPE_WIDTH = 6;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 6'h01;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 6'h02;

  localparam logic COEFF_SEL_COL = 1'b0;
  localparam logic COEFF_SEL_ROW = 1'b1;

  localparam int CHECKSUM_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_COPY_COL = 3'd2,
    ST_COPY_ROW = 3'd3,
    ST_DONE     = 3'd4
  } vuc_state_t;

  // Number of table entries when one coefficient covers 2^shift pixels.
  function automatic int ceil_shift(input int n, input int shift);
    return (n + (1 << shift) - 1) >> shift;
  endfunction

  // Address bits needed to index a table of the given depth (at least 1).
  function automatic int addr_bits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/vignette_stage_ram.sv
// Staging storage for the column and row gain tables. One write port for
// software, one read port for the copy engine; reads return one cycle later.
module vignette_stage_ram
  import vignette_update_ctrl_pkg::*;
#(
  parameter int GAIN_WIDTH = 8,
  parameter int COL_AW     = 3,
  parameter int ROW_AW     = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  wsel,
  input  logic [COL_AW-1:0]     wcol_addr,
  input  logic [ROW_AW-1:0]     wrow_addr,
  input  logic [GAIN_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic                  rsel,
  input  logic [COL_AW-1:0]     rcol_addr,
  input  logic [ROW_AW-1:0]     rrow_addr,
  output logic [GAIN_WIDTH-1:0] rdata
);

  logic [GAIN_WIDTH-1:0] col_mem [0:(1<<COL_AW)-1];
  logic [GAIN_WIDTH-1:0] row_mem [0:(1<<ROW_AW)-1];

  // Table write and registered read; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      if (wsel == COEFF_SEL_ROW) row_mem[wrow_addr] <= wdata;
      else                       col_mem[wcol_addr] <= wdata;
    end
    if (re) begin
      rdata <= (rsel == COEFF_SEL_ROW) ? row_mem[rrow_addr] : col_mem[rcol_addr];
    end
  end

endmodule

// File: rtl/vignette_update_ctrl.sv
// Frame-synchronous vignette coefficient loader. Software stages column and
// row gains, pulses commit, and the table is copied into the vignette coeff
// RAMs at the next frame end. vig_enable only changes at frame start and is
// held low for any frame that starts while the copy is still running.
// Optional build macro: VIGNETTE_UPDATE_CHECKSUM_EN adds a 16-bit running
// sum of the copied coefficients on the checksum port.
// Handshake: a staging write is taken on any cycle where stage_we and
// stage_rdy are both high and stage_addr is inside the selected table;
// otherwise it is silently dropped.
module vignette_update_ctrl
  import vignette_update_ctrl_pkg::*;
#(
  parameter int GAIN_WIDTH      = 8,
  parameter int DIM_WIDTH       = 11,
  parameter int NUM_COLS        = 1286,
  parameter int NUM_ROWS        = 728,
  parameter int SUBSAMPLE_SHIFT = 0,
  parameter int OVR_CNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     resetb_clk,
  input  logic                     dvi,
  input  logic [DTYPE_WIDTH-1:0]   dtypei,
  input  logic                     user_enable,
  input  logic                     stage_we,
  input  logic                     stage_sel,
  input  logic [DIM_WIDTH-1:0]     stage_addr,
  input  logic [GAIN_WIDTH-1:0]    stage_data,
  output logic                     stage_rdy,
  input  logic                     commit,
  output logic                     coeff_we,
  output logic                     coeff_sel,
  output logic [DIM_WIDTH-1:0]     coeff_addr,
  output logic [GAIN_WIDTH-1:0]    coeff_data,
  output logic                     vig_enable,
  output logic                     busy,
  output logic                     done,
  output logic [OVR_CNT_WIDTH-1:0] overrun_cnt,
`ifdef VIGNETTE_UPDATE_CHECKSUM_EN
  output logic [CHECKSUM_WIDTH-1:0] checksum,
`endif
  output logic [2:0]               dbg_state
);

  localparam int SC     = ceil_shift(NUM_COLS, SUBSAMPLE_SHIFT);
  localparam int SR     = ceil_shift(NUM_ROWS, SUBSAMPLE_SHIFT);
  localparam int COL_AW = addr_bits(SC);
  localparam int ROW_AW = addr_bits(SR);
  localparam logic [31:0] SC_U = 32'(SC);
  localparam logic [31:0] SR_U = 32'(SR);
  localparam logic [DIM_WIDTH-1:0] SC_LAST = DIM_WIDTH'(SC - 1);
  localparam logic [DIM_WIDTH-1:0] SR_LAST = DIM_WIDTH'(SR - 1);

  vuc_state_t state, state_nxt;
  logic [DIM_WIDTH-1:0]     cnt;
  logic                     frame_start, frame_end, copying;
  logic                     rd_en, rd_sel, in_range, stage_ok;
  logic [GAIN_WIDTH-1:0]    rd_data;
  logic                     coeff_we_q, coeff_sel_q, done_q, vig_en_q;
  logic [DIM_WIDTH-1:0]     coeff_addr_q;
  logic [OVR_CNT_WIDTH-1:0] ovr_q;

  assign frame_start = dvi && (dtypei == DTYPE_FRAME_START);
  assign frame_end   = dvi && (dtypei == DTYPE_FRAME_END);
  assign copying     = (state == ST_COPY_COL) || (state == ST_COPY_ROW);
  assign in_range    = (stage_sel == COEFF_SEL_ROW) ? (32'(stage_addr) < SR_U)
                                                    : (32'(stage_addr) < SC_U);
  assign stage_ok    = stage_we && stage_rdy && in_range;

  vignette_stage_ram #(
    .GAIN_WIDTH (GAIN_WIDTH),
    .COL_AW     (COL_AW),
    .ROW_AW     (ROW_AW)
  ) u_stage_ram (
    .clk       (clk),
    .we        (stage_ok),
    .wsel      (stage_sel),
    .wcol_addr (stage_addr[COL_AW-1:0]),
    .wrow_addr (stage_addr[ROW_AW-1:0]),
    .wdata     (stage_data),
    .re        (rd_en),
    .rsel      (rd_sel),
    .rcol_addr (cnt[COL_AW-1:0]),
    .rrow_addr (cnt[ROW_AW-1:0]),
    .rdata     (rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge resetb_clk) begin
    if (!resetb_clk) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next state, staging read request and staging-port readiness.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_sel    = COEFF_SEL_COL;
    stage_rdy = 1'b1;
    case (state)
      ST_IDLE:  if (commit) state_nxt = ST_ARMED;
      ST_ARMED: if (frame_end) state_nxt = ST_COPY_COL;
      ST_COPY_COL: begin
        rd_en     = 1'b1;
        stage_rdy = 1'b0;
        if (cnt == SC_LAST) state_nxt = ST_COPY_ROW;
      end
      ST_COPY_ROW: begin
        rd_en     = 1'b1;
        rd_sel    = COEFF_SEL_ROW;
        stage_rdy = 1'b0;
        if (cnt == SR_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        stage_rdy = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Copy address: restarts at zero for each table.
  always_ff @(posedge clk or negedge resetb_clk) begin
    if (!resetb_clk)               cnt <= '0;
    else if (rd_en && state_nxt == state) cnt <= cnt + 1'b1;
    else                           cnt <= '0;
  end

  // Coefficient write strobe/address follow the read by one cycle to line up with RAM data.
  always_ff @(posedge clk or negedge resetb_clk) begin
    if (!resetb_clk) begin
      coeff_we_q   <= 1'b0;
      coeff_sel_q  <= 1'b0;
      coeff_addr_q <= '0;
      done_q       <= 1'b0;
    end else begin
      coeff_we_q   <= rd_en;
      coeff_sel_q  <= rd_en ? rd_sel : 1'b0;
      coeff_addr_q <= rd_en ? cnt : '0;
      done_q       <= (state == ST_DONE);
    end
  end

  // Frame-start sampling of the enable and the saturating overrun counter.
  always_ff @(posedge clk or negedge resetb_clk) begin
    if (!resetb_clk) begin
      vig_en_q <= 1'b0;
      ovr_q    <= '0;
    end else if (frame_start) begin
      vig_en_q <= user_enable && ((state == ST_IDLE) || (state == ST_ARMED));
      if (copying && (ovr_q != '1)) ovr_q <= ovr_q + 1'b1;
    end
  end

`ifdef VIGNETTE_UPDATE_CHECKSUM_EN
  logic [CHECKSUM_WIDTH-1:0] checksum_q;

  // Running sum of written coefficients, cleared as each copy begins.
  always_ff @(posedge clk or negedge resetb_clk) begin
    if (!resetb_clk)                           checksum_q <= '0;
    else if (state == ST_ARMED && frame_end)   checksum_q <= '0;
    else if (coeff_we_q)                       checksum_q <= checksum_q + CHECKSUM_WIDTH'(coeff_data);
  end

  assign checksum = checksum_q;
`endif

  assign coeff_we    = coeff_we_q;
  assign coeff_sel   = coeff_sel_q;
  assign coeff_addr  = coeff_addr_q;
  assign coeff_data  = coeff_we_q ? rd_data : '0;
  assign vig_enable  = vig_en_q;
  assign busy        = (state != ST_IDLE);
  assign done        = done_q;
  assign overrun_cnt = ovr_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_vignette_update_ctrl.sv
// Directed bench for vignette_update_ctrl with an 8x4 table.
module tb_vignette_update_ctrl;
  import vignette_update_ctrl_pkg::*;

  localparam int GW = 8;
  localparam int DW = 11;
  localparam int NC = 8;
  localparam int NR = 4;
  localparam int OW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetb_clk = 1'b0;
  always #5 clk = ~clk;

  logic                   dvi = 1'b0;
  logic [DTYPE_WIDTH-1:0] dtypei = '0;
  logic                   user_enable = 1'b0;
  logic                   stage_we = 1'b0;
  logic                   stage_sel = 1'b0;
  logic [DW-1:0]          stage_addr = '0;
  logic [GW-1:0]          stage_data = '0;
  logic                   commit = 1'b0;
  logic                   stage_rdy, coeff_we, coeff_sel, vig_enable, busy, done;
  logic [DW-1:0]          coeff_addr;
  logic [GW-1:0]          coeff_data;
  logic [OW-1:0]          overrun_cnt;
  logic [2:0]             dbg_state;
`ifdef VIGNETTE_UPDATE_CHECKSUM_EN
  logic [15:0]            checksum;
`endif

  vignette_update_ctrl #(
    .GAIN_WIDTH(GW), .DIM_WIDTH(DW), .NUM_COLS(NC), .NUM_ROWS(NR),
    .SUBSAMPLE_SHIFT(0), .OVR_CNT_WIDTH(OW)
  ) dut (
    .clk(clk), .resetb_clk(resetb_clk), .dvi(dvi), .dtypei(dtypei),
    .user_enable(user_enable), .stage_we(stage_we), .stage_sel(stage_sel),
    .stage_addr(stage_addr), .stage_data(stage_data), .stage_rdy(stage_rdy),
    .commit(commit), .coeff_we(coeff_we), .coeff_sel(coeff_sel),
    .coeff_addr(coeff_addr), .coeff_data(coeff_data), .vig_enable(vig_enable),
    .busy(busy), .done(done), .overrun_cnt(overrun_cnt),
`ifdef VIGNETTE_UPDATE_CHECKSUM_EN
    .checksum(checksum),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [GW-1:0] exp_col [NC];
  logic [GW-1:0] exp_row [NR];
  logic [GW-1:0] exp_q [$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stage_write(input logic sel, input int addr, input int data);
    stage_we = 1'b1; stage_sel = sel; stage_addr = DW'(addr); stage_data = GW'(data);
    tick();
    stage_we = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic pulse_event(input logic [DTYPE_WIDTH-1:0] dt);
    dvi = 1'b1; dtypei = dt;
    tick();
    dvi = 1'b0; dtypei = '0;
  endtask

  // Drive FRAME_END from ARMED and score the whole copy against the model tables.
  task automatic run_copy(input string tag);
    int sum;
    int k;
    exp_q.delete();
    for (int i = 0; i < NC; i++) exp_q.push_back(exp_col[i]);
    for (int i = 0; i < NR; i++) exp_q.push_back(exp_row[i]);
    sum = 0;
    foreach (exp_q[i]) sum += int'(exp_q[i]);
    pulse_event(DTYPE_FRAME_END);
    n_checks++; if (coeff_we !== 1'b0) $display("FAIL %s_we_early: got %b want 0", tag, coeff_we); else n_pass++;
    n_checks++; if (stage_rdy !== 1'b0) $display("FAIL %s_rdy_copy: got %b want 0", tag, stage_rdy); else n_pass++;
    k = 0;
    while (exp_q.size() > 0) begin
      logic [GW-1:0] ed;
      logic          es;
      logic [DW-1:0] ea;
      tick();
      ed = exp_q.pop_front();
      es = (k >= NC);
      ea = es ? DW'(k - NC) : DW'(k);
      n_checks++;
      if (coeff_we !== 1'b1 || coeff_sel !== es || coeff_addr !== ea || coeff_data !== ed || done !== 1'b0)
        $display("FAIL %s_wr%0d: got we=%b sel=%b addr=%0d data=%0h done=%b want we=1 sel=%b addr=%0d data=%0h done=0",
                 tag, k, coeff_we, coeff_sel, coeff_addr, coeff_data, done, es, ea, ed);
      else n_pass++;
      k++;
    end
    tick();
    n_checks++; if (done !== 1'b1 || coeff_we !== 1'b0) $display("FAIL %s_done: got done=%b we=%b want done=1 we=0", tag, done, coeff_we); else n_pass++;
    n_checks++; if (busy !== 1'b0 || stage_rdy !== 1'b1) $display("FAIL %s_idle: got busy=%b rdy=%b want busy=0 rdy=1", tag, busy, stage_rdy); else n_pass++;
`ifdef VIGNETTE_UPDATE_CHECKSUM_EN
    n_checks++; if (checksum !== 16'(sum)) $display("FAIL %s_checksum: got %0h want %0h", tag, checksum, 16'(sum)); else n_pass++;
`endif
    k = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (coeff_we !== 1'b0 || done !== 1'b0) k++;
    end
    n_checks++; if (k != 0) $display("FAIL %s_quiet_after: got %0d active cycles want 0", tag, k); else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetb_clk = 1'b0;
    tick(); tick();
    n_checks++; if (coeff_we !== 0 || coeff_sel !== 0 || coeff_addr !== 0 || coeff_data !== 0)
      $display("FAIL reset_coeff: got we=%b sel=%b addr=%0d data=%0h want all 0", coeff_we, coeff_sel, coeff_addr, coeff_data); else n_pass++;
    n_checks++; if (vig_enable !== 0 || busy !== 0 || done !== 0 || overrun_cnt !== 0)
      $display("FAIL reset_status: got vig=%b busy=%b done=%b ovr=%0d want all 0", vig_enable, busy, done, overrun_cnt); else n_pass++;
    n_checks++; if (stage_rdy !== 1'b1 || dbg_state !== 3'd0)
      $display("FAIL reset_rdy_state: got rdy=%b state=%0d want rdy=1 state=0", stage_rdy, dbg_state); else n_pass++;
    resetb_clk = 1'b1;
    tick();
  endtask

  task automatic test_basic_copy();
    for (int i = 0; i < NC; i++) begin stage_write(COEFF_SEL_COL, i, i + 10); exp_col[i] = GW'(i + 10); end
    for (int i = 0; i < NR; i++) begin stage_write(COEFF_SEL_ROW, i, i + 20); exp_row[i] = GW'(i + 20); end
    pulse_commit();
    n_checks++; if (dbg_state !== 3'd1 || busy !== 1'b1 || stage_rdy !== 1'b1)
      $display("FAIL basic_armed: got state=%0d busy=%b rdy=%b want 1 1 1", dbg_state, busy, stage_rdy); else n_pass++;
    run_copy("basic");
  endtask

  task automatic test_overrun();
    user_enable = 1'b1;
    pulse_event(DTYPE_FRAME_START);
    n_checks++; if (vig_enable !== 1'b1) $display("FAIL ovr_enable_idle: got %b want 1", vig_enable); else n_pass++;
    pulse_commit();
    pulse_event(DTYPE_FRAME_END);
    for (int i = 0; i < 4; i++) tick();
    pulse_event(DTYPE_FRAME_START);
    n_checks++; if (overrun_cnt !== 8'd1) $display("FAIL ovr_count: got %0d want 1", overrun_cnt); else n_pass++;
    n_checks++; if (vig_enable !== 1'b0) $display("FAIL ovr_forced_off: got %b want 0", vig_enable); else n_pass++;
    n_checks++; if (coeff_we !== 1'b1 || busy !== 1'b1) $display("FAIL ovr_continues: got we=%b busy=%b want 1 1", coeff_we, busy); else n_pass++;
    for (int i = 0; i < 12; i++) tick();
    n_checks++; if (busy !== 1'b0 || vig_enable !== 1'b0) $display("FAIL ovr_finish: got busy=%b vig=%b want 0 0", busy, vig_enable); else n_pass++;
    pulse_event(DTYPE_FRAME_START);
    n_checks++; if (vig_enable !== 1'b1 || overrun_cnt !== 8'd1)
      $display("FAIL ovr_next_frame: got vig=%b ovr=%0d want vig=1 ovr=1", vig_enable, overrun_cnt); else n_pass++;
    user_enable = 1'b0;
    pulse_event(DTYPE_FRAME_START);
    n_checks++; if (vig_enable !== 1'b0) $display("FAIL ovr_user_off: got %b want 0", vig_enable); else n_pass++;
  endtask

  task automatic test_commit_on_frame_end();
    int bad;
    commit = 1'b1; dvi = 1'b1; dtypei = DTYPE_FRAME_END;
    tick();
    commit = 1'b0; dvi = 1'b0; dtypei = '0;
    n_checks++; if (dbg_state !== 3'd1) $display("FAIL same_cycle_armed: got state=%0d want 1", dbg_state); else n_pass++;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (coeff_we !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL same_cycle_no_copy: got %0d writes want 0", bad); else n_pass++;
    run_copy("same_cycle");
  endtask

  task automatic test_stage_blocking();
    pulse_commit();
    pulse_event(DTYPE_FRAME_END);
    tick();
    n_checks++; if (stage_rdy !== 1'b0) $display("FAIL block_rdy: got %b want 0", stage_rdy); else n_pass++;
    stage_write(COEFF_SEL_COL, 0, 8'hAA);
    for (int i = 0; i < 14; i++) tick();
    n_checks++; if (busy !== 1'b0 || stage_rdy !== 1'b1) $display("FAIL block_idle: got busy=%b rdy=%b want 0 1", busy, stage_rdy); else n_pass++;
    stage_write(COEFF_SEL_COL, 8, 8'h55);
    stage_write(COEFF_SEL_ROW, 4, 8'h66);
    pulse_commit();
    stage_write(COEFF_SEL_COL, 3, 8'h33);
    exp_col[3] = 8'h33;
    run_copy("blocking");
  endtask

  task automatic test_double_commit_and_reset();
    int active;
    pulse_commit();
    pulse_commit();
    run_copy("double_commit");
    pulse_commit();
    pulse_event(DTYPE_FRAME_END);
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (coeff_we !== 1'b1) $display("FAIL midcopy_active: got we=%b want 1", coeff_we); else n_pass++;
    resetb_clk = 1'b0;
    #1;
    n_checks++; if (coeff_we !== 0 || coeff_sel !== 0 || coeff_addr !== 0 || coeff_data !== 0)
      $display("FAIL midreset_coeff: got we=%b sel=%b addr=%0d data=%0h want all 0", coeff_we, coeff_sel, coeff_addr, coeff_data); else n_pass++;
    n_checks++; if (vig_enable !== 0 || busy !== 0 || done !== 0 || overrun_cnt !== 0)
      $display("FAIL midreset_status: got vig=%b busy=%b done=%b ovr=%0d want all 0", vig_enable, busy, done, overrun_cnt); else n_pass++;
    n_checks++; if (stage_rdy !== 1'b1 || dbg_state !== 3'd0)
      $display("FAIL midreset_state: got rdy=%b state=%0d want rdy=1 state=0", stage_rdy, dbg_state); else n_pass++;
    tick();
    resetb_clk = 1'b1;
    active = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (coeff_we !== 1'b0 || busy !== 1'b0) active++;
    end
    n_checks++; if (active != 0) $display("FAIL after_reset_quiet: got %0d active cycles want 0", active); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_copy();
    test_overrun();
    test_commit_on_frame_end();
    test_stage_blocking();
    test_double_commit_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule
